// File: rtl/ttt_pkg.sv
// Shared constants for the tic-tac-toe board controller: board geometry,
// FSM state encoding and winner codes.
package ttt_pkg;

    localparam int NSQ    = 9;
    localparam int NLINES = 8;

    localparam logic [1:0] S_TURN_A = 2'd0;
    localparam logic [1:0] S_TURN_B = 2'd1;
    localparam logic [1:0] S_CHECK  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_A    = 2'b01;
    localparam logic [1:0] W_B    = 2'b10;

endpackage

// File: rtl/ttt_board_ctrl_if.sv
// Move request handshake between the move source (master) and the board
// controller (slave), including the controller's rejection pulse.
interface ttt_board_ctrl_if;
    import ttt_pkg::*;

    logic           move_valid;
    logic [NSQ-1:0] move_sq;
    logic           move_ready;
    logic           illegal;

    modport master (
        output move_valid,
        output move_sq,
        input  move_ready,
        input  illegal
    );

    modport slave (
        input  move_valid,
        input  move_sq,
        output move_ready,
        output illegal
    );
endinterface

// File: rtl/ttt_move_legal.sv
// Combinational move legality: the request must select exactly one square
// and that square must not already be occupied by either player.
module ttt_move_legal
    import ttt_pkg::*;
(
    input  logic [NSQ-1:0] move_sq,
    input  logic [NSQ-1:0] occ,
    output logic           legal
);

    // Running popcount across the squares; cnt_chain[NSQ] is the total.
    logic [3:0] cnt_chain [0:NSQ];

    assign cnt_chain[0] = 4'd0;

    generate
        for (genvar gi = 0; gi < NSQ; gi++) begin : g_pop
            assign cnt_chain[gi+1] = cnt_chain[gi] + {3'b000, move_sq[gi]};
        end
    endgenerate

    assign legal = (cnt_chain[NSQ] == 4'd1) && ((move_sq & occ) == '0);

endmodule

// File: rtl/ttt_board_ctrl.sv
// Tic-tac-toe game sequencer: accepts alternating moves, keeps both occupancy
// boards, and consumes external win-line flags to declare a win or a draw.
module ttt_board_ctrl
    import ttt_pkg::*;
#(
    parameter bit FIRST_PLAYER = 1'b0,
    parameter bit ALT_FIRST    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              new_game,
    ttt_board_ctrl_if.slave   mv,
    input  logic [NLINES-1:0] win_a,
    input  logic [NLINES-1:0] win_b,
    output logic [NSQ-1:0]    ain,
    output logic [NSQ-1:0]    bin,
    output logic              turn,
    output logic              game_over,
    output logic [1:0]        winner,
    output logic [NLINES-1:0] win_line_q,
    output logic [3:0]        move_cnt
);

    localparam logic [1:0] S_OPEN = FIRST_PLAYER ? S_TURN_B : S_TURN_A;

    logic [1:0]        state_reg,    state_next;
    logic [NSQ-1:0]    ain_reg,      ain_next;
    logic [NSQ-1:0]    bin_reg,      bin_next;
    logic [3:0]        cnt_reg,      cnt_next;
    logic [1:0]        winner_reg,   winner_next;
    logic [NLINES-1:0] win_line_reg, win_line_next;
    logic              turn_reg,     turn_next;
    logic              illegal_reg,  illegal_next;
    logic              opener_reg,   opener_next;

    logic              legal;
    logic [NLINES-1:0] mover_flags;

    ttt_move_legal u_legal (
        .move_sq (mv.move_sq),
        .occ     (ain_reg | bin_reg),
        .legal   (legal)
    );

    // Only the mover's detector can have changed on the move just placed.
    assign mover_flags = turn_reg ? win_b : win_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_OPEN;
            ain_reg      <= '0;
            bin_reg      <= '0;
            cnt_reg      <= 4'd0;
            winner_reg   <= W_NONE;
            win_line_reg <= '0;
            turn_reg     <= FIRST_PLAYER;
            illegal_reg  <= 1'b0;
            opener_reg   <= FIRST_PLAYER;
        end else begin
            state_reg    <= state_next;
            ain_reg      <= ain_next;
            bin_reg      <= bin_next;
            cnt_reg      <= cnt_next;
            winner_reg   <= winner_next;
            win_line_reg <= win_line_next;
            turn_reg     <= turn_next;
            illegal_reg  <= illegal_next;
            opener_reg   <= opener_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        ain_next      = ain_reg;
        bin_next      = bin_reg;
        cnt_next      = cnt_reg;
        winner_next   = winner_reg;
        win_line_next = win_line_reg;
        turn_next     = turn_reg;
        illegal_next  = 1'b0;
        opener_next   = opener_reg;

        if (new_game) begin
            // A same-cycle move request is dropped silently.
            opener_next   = ALT_FIRST ? ~opener_reg : FIRST_PLAYER;
            state_next    = opener_next ? S_TURN_B : S_TURN_A;
            turn_next     = opener_next;
            ain_next      = '0;
            bin_next      = '0;
            cnt_next      = 4'd0;
            winner_next   = W_NONE;
            win_line_next = '0;
        end else begin
            case (state_reg)
                S_TURN_A, S_TURN_B: begin
                    if (mv.move_valid) begin
                        if (legal) begin
                            if (turn_reg) bin_next = bin_reg | mv.move_sq;
                            else          ain_next = ain_reg | mv.move_sq;
                            if (cnt_reg != 4'd9) cnt_next = cnt_reg + 4'd1;
                            state_next = S_CHECK;
                        end else begin
                            illegal_next = 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (mover_flags != '0) begin
                        state_next    = S_DONE;
                        winner_next   = turn_reg ? W_B : W_A;
                        win_line_next = mover_flags;
                    end else if (cnt_reg == 4'd9) begin
                        state_next    = S_DONE;
                        winner_next   = W_NONE;
                        win_line_next = '0;
                    end else begin
                        state_next = turn_reg ? S_TURN_A : S_TURN_B;
                        turn_next  = ~turn_reg;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        mv.move_ready = (state_reg == S_TURN_A) || (state_reg == S_TURN_B);
        game_over     = (state_reg == S_DONE);
    end

    assign mv.illegal = illegal_reg;
    assign ain        = ain_reg;
    assign bin        = bin_reg;
    assign turn       = turn_reg;
    assign winner     = winner_reg;
    assign win_line_q = win_line_reg;
    assign move_cnt   = cnt_reg;

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// Directed bench for ttt_board_ctrl with a behavioural line detector standing
// in for the two DetectWinner instances.
module tb_ttt_board_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       new_game;
    logic [7:0] win_a, win_b;
    logic [8:0] ain, bin;
    logic       turn, game_over;
    logic [1:0] winner;
    logic [7:0] win_line_q;
    logic [3:0] move_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    ttt_board_ctrl_if mv_if ();

    ttt_board_ctrl #(.FIRST_PLAYER(1'b0), .ALT_FIRST(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .new_game   (new_game),
        .mv         (mv_if),
        .win_a      (win_a),
        .win_b      (win_b),
        .ain        (ain),
        .bin        (bin),
        .turn       (turn),
        .game_over  (game_over),
        .winner     (winner),
        .win_line_q (win_line_q),
        .move_cnt   (move_cnt)
    );

    always #5 clk = ~clk;

    // Line flags: bit0..2 rows top..bottom, bit3..5 columns left..right, bit6/7 diagonals.
    function automatic logic [7:0] detect(input logic [8:0] b);
        logic [7:0] f;
        f[0] = b[8] & b[7] & b[6];
        f[1] = b[5] & b[4] & b[3];
        f[2] = b[2] & b[1] & b[0];
        f[3] = b[8] & b[5] & b[2];
        f[4] = b[7] & b[4] & b[1];
        f[5] = b[6] & b[3] & b[0];
        f[6] = b[8] & b[4] & b[0];
        f[7] = b[6] & b[4] & b[2];
        return f;
    endfunction

    assign win_a = detect(ain);
    assign win_b = detect(bin);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-16s got=%0h exp=%0h ok", tag, got, exp);
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a move for one edge; on return the accept edge has passed.
    task automatic do_move(input logic [8:0] sq);
        mv_if.move_valid = 1'b1;
        mv_if.move_sq    = sq;
        tick();
        mv_if.move_valid = 1'b0;
        mv_if.move_sq    = '0;
    endtask

    task automatic play(input logic [8:0] sq);
        do_move(sq);
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n            = 1'b0;
        new_game         = 1'b0;
        mv_if.move_valid = 1'b0;
        mv_if.move_sq    = '0;

        // 1: reset state
        #12;
        check("rst_ain",   ain, 0);
        check("rst_bin",   bin, 0);
        check("rst_turn",  turn, 0);
        check("rst_ready", mv_if.move_ready, 1);
        check("rst_over",  game_over, 0);
        check("rst_win",   winner, 0);
        check("rst_cnt",   move_cnt, 0);
        rst_n = 1'b1;
        tick();

        // 2: A wins on the top row
        play(9'h100);
        check("t2_turn_b", turn, 1);
        play(9'h020);
        play(9'h080);
        play(9'h010);
        do_move(9'h040);
        check("t2_chk_over",  game_over, 0);
        check("t2_chk_ready", mv_if.move_ready, 0);
        tick();
        check("t2_over",  game_over, 1);
        check("t2_win",   winner, 2'b01);
        check("t2_ain",   ain, 9'h1C0);
        check("t2_line",  win_line_q, 8'h01);
        check("t2_ready", mv_if.move_ready, 0);
        check("t2_cnt",   move_cnt, 5);

        // 3: illegal moves
        do_reset();
        play(9'h100);
        do_move(9'h100);
        check("t3_ill1",   mv_if.illegal, 1);
        check("t3_bin",    bin, 0);
        check("t3_turn",   turn, 1);
        check("t3_cnt",    move_cnt, 1);
        tick();
        check("t3_pulse",  mv_if.illegal, 0);
        do_move(9'h003);
        check("t3_ill2",   mv_if.illegal, 1);
        check("t3_bin2",   bin, 0);
        do_move(9'h001);
        check("t3_ok_ill", mv_if.illegal, 0);
        check("t3_ok_bin", bin, 9'h001);
        check("t3_ok_cnt", move_cnt, 2);
        tick();

        // 4: draw
        do_reset();
        play(9'h100); play(9'h010); play(9'h080); play(9'h040); play(9'h004);
        play(9'h020); play(9'h008); play(9'h002);
        do_move(9'h001);
        tick();
        check("t4_over", game_over, 1);
        check("t4_win",  winner, 2'b00);
        check("t4_cnt",  move_cnt, 9);
        check("t4_line", win_line_q, 0);
        check("t4_ain",  ain, 9'h18D);
        check("t4_bin",  bin, 9'h072);
        // move request in DONE is ignored
        do_move(9'h100);
        check("t4_ign_ill",  mv_if.illegal, 0);
        check("t4_ign_over", game_over, 1);

        // 5: new_game beats a same-cycle move; opener alternates to B
        new_game         = 1'b1;
        mv_if.move_valid = 1'b1;
        mv_if.move_sq    = 9'h100;
        tick();
        new_game         = 1'b0;
        mv_if.move_valid = 1'b0;
        mv_if.move_sq    = '0;
        check("t5_ain",   ain, 0);
        check("t5_bin",   bin, 0);
        check("t5_ill",   mv_if.illegal, 0);
        check("t5_turn",  turn, 1);
        check("t5_ready", mv_if.move_ready, 1);
        check("t5_cnt",   move_cnt, 0);
        check("t5_over",  game_over, 0);
        // B opens and wins the top row
        play(9'h100); play(9'h020); play(9'h080); play(9'h010);
        do_move(9'h040);
        tick();
        check("t5_bwin",  winner, 2'b10);
        check("t5_bbin",  bin, 9'h1C0);
        check("t5_bain",  ain, 9'h030);
        check("t5_bline", win_line_q, 8'h01);

        // 6: async reset while in CHECK
        do_reset();
        do_move(9'h010);
        check("t6_pre_ain", ain, 9'h010);
        rst_n = 1'b0;
        #1;
        check("t6_ain",   ain, 0);
        check("t6_cnt",   move_cnt, 0);
        check("t6_turn",  turn, 0);
        check("t6_ready", mv_if.move_ready, 1);
        check("t6_over",  game_over, 0);
        check("t6_win",   winner, 0);
        check("t6_line",  win_line_q, 0);
        check("t6_ill",   mv_if.illegal, 0);
        #2;
        rst_n = 1'b1;
        tick();
        check("t6_after", mv_if.move_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
